// File: rtl/inv_s_box_seq.sv
// Sequential AES inverse S-box: inverse affine, then x^254 by square-and-multiply.
// Optional forward mode (fwd_mode port) is enabled by defining SBOX_FWD_MODE_EN.
module inv_s_box_seq #(
    parameter logic [7:0] IRRED_POLY = 8'h1B
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] inputValue,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef SBOX_FWD_MODE_EN
    input  logic       fwd_mode,
`endif
    output logic [7:0] sboxOutput
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT      state, stateNext;
    logic [7:0] sq, sqNext;
    logic [7:0] acc, accNext;
    logic [2:0] cnt, cntNext;
    logic [7:0] outNext;
    logic [7:0] sqSq, accMul, finalByte, captured;

    function automatic logic [7:0] gfMul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = t[7] ? ({t[6:0], 1'b0} ^ IRRED_POLY) : {t[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] invAffine(input logic [7:0] b);
        return {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
    endfunction

`ifdef SBOX_FWD_MODE_EN
    logic fwdReg, fwdNext;

    function automatic logic [7:0] fwdAffine(input logic [7:0] b);
        return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]}
                 ^ {b[5:0], b[7:6]} ^ {b[6:0], b[7]} ^ 8'h63;
    endfunction

    assign captured  = fwd_mode ? inputValue : invAffine(inputValue);
    assign finalByte = fwdReg ? fwdAffine(accMul) : accMul;
`else
    assign captured  = invAffine(inputValue);
    assign finalByte = accMul;
`endif

    assign sqSq      = gfMul(sq, sq);
    assign accMul    = gfMul(acc, sqSq);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        stateNext = state;
        sqNext    = sq;
        accNext   = acc;
        cntNext   = cnt;
        outNext   = sboxOutput;
`ifdef SBOX_FWD_MODE_EN
        fwdNext   = fwdReg;
`endif
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    sqNext    = captured;
                    accNext   = 8'h01;
                    cntNext   = 3'd0;
                    stateNext = EXP;
`ifdef SBOX_FWD_MODE_EN
                    fwdNext   = fwd_mode;
`endif
                end
            end
            EXP: begin
                sqNext  = sqSq;
                accNext = accMul;
                cntNext = cnt + 3'd1;
                // seventh square-and-multiply leaves acc = a^254
                if (cnt == 3'd6) begin
                    outNext   = finalByte;
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (out_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sq         <= 8'h00;
            acc        <= 8'h00;
            cnt        <= 3'd0;
            sboxOutput <= 8'h00;
`ifdef SBOX_FWD_MODE_EN
            fwdReg     <= 1'b0;
`endif
        end else begin
            state      <= stateNext;
            sq         <= sqNext;
            acc        <= accNext;
            cnt        <= cntNext;
            sboxOutput <= outNext;
`ifdef SBOX_FWD_MODE_EN
            fwdReg     <= fwdNext;
`endif
        end
    end

endmodule

// File: tb/tb_inv_s_box_seq.sv
// Randomized and directed bench for inv_s_box_seq against a field-arithmetic model.
// Field inverse found by exhaustive search; affine maps built from byte rotations.
module tb_inv_s_box_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] inputValue;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sboxOutput;
`ifdef SBOX_FWD_MODE_EN
    logic       fwd_mode = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    inv_s_box_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inputValue (inputValue),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef SBOX_FWD_MODE_EN
        .fwd_mode   (fwd_mode),
`endif
        .sboxOutput (sboxOutput)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        logic [15:0] w;
        w = {b, b} << k;
        return w[15:8];
    endfunction

    function automatic logic [7:0] mulRef(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] invRef(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        for (int y = 1; y < 256; y++)
            if (mulRef(x, 8'(y)) == 8'h01) r = 8'(y);
        return r;
    endfunction

    function automatic logic [7:0] refInv(input logic [7:0] v);
        return invRef(rotl(v, 1) ^ rotl(v, 3) ^ rotl(v, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] refFwd(input logic [7:0] v);
        logic [7:0] b;
        b = invRef(v);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    task automatic waitOut(output int lat, output logic [7:0] res);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        if (!out_valid) check("timeout", 32'(out_valid), 32'd1);
        res = sboxOutput;
    endtask

    task automatic runByte(input logic [7:0] v, input int holdOff,
                           output logic [7:0] res, output int lat);
        @(negedge clk);
        check("inReadyIdle", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        inputValue = v;
        out_ready  = (holdOff == 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("inReadyBusy", 32'(in_ready), 32'd0);
        waitOut(lat, res);
        lat++;
        for (int i = 0; i < holdOff; i++) begin
            @(negedge clk);
            check("holdValid", 32'(out_valid), 32'd1);
            check("holdData", 32'(sboxOutput), 32'(res));
        end
        out_ready = 1'b1;
    endtask

    logic [7:0] dirIn  [7] = '{8'h63, 8'hf5, 8'hc1, 8'h7c, 8'h16, 8'h00, 8'hff};
    logic [7:0] dirOut [7] = '{8'h00, 8'h77, 8'hdd, 8'h01, 8'hff, 8'h52, 8'h7d};

    initial begin
        logic [7:0] res;
        logic [7:0] v;
        int         lat;

        reset_n    = 1'b0;
        in_valid   = 1'b1;
        inputValue = 8'h63;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rstInReady", 32'(in_ready), 32'd1);
        check("rstOutValid", 32'(out_valid), 32'd0);
        check("rstData", 32'(sboxOutput), 32'd0);
        reset_n = 1'b1;
        #1;
        check("relInReady", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("firstCapture", 32'(in_ready), 32'd0);
        waitOut(lat, res);
        check("firstLat", 32'(lat), 32'd7);
        check("firstData", 32'(res), 32'h00);

        for (int i = 0; i < 7; i++) begin
            runByte(dirIn[i], 0, res, lat);
            check("dirLat", 32'(lat), 32'd8);
            check("dirConst", 32'(res), 32'(dirOut[i]));
            check("dirModel", 32'(res), 32'(refInv(dirIn[i])));
        end
        runByte(8'h52, 0, res, lat);
        check("dir52", 32'(res), 32'(refInv(8'h52)));

        for (int i = 0; i < 40; i++) begin
            v = 8'($urandom);
            runByte(v, int'($urandom_range(0, 3)), res, lat);
            check("rndData", 32'(res), 32'(refInv(v)));
            check("rndLat", 32'(lat), 32'd8);
        end

        runByte(8'hf5, 20, res, lat);
        check("bpData", 32'(res), 32'h77);
        @(negedge clk);
        check("bpDoneValid", 32'(out_valid), 32'd0);
        check("bpDoneReady", 32'(in_ready), 32'd1);

        @(negedge clk);
        in_valid   = 1'b1;
        inputValue = 8'hf5;
        out_ready  = 1'b0;
        @(negedge clk);
        inputValue = 8'h16;
        for (int i = 0; i < 12; i++) begin
            in_valid = ~in_valid;
            @(negedge clk);
            if (i > 8) begin
                check("ignValid", 32'(out_valid), 32'd1);
                check("ignData", 32'(sboxOutput), 32'h77);
                check("ignReady", 32'(in_ready), 32'd0);
            end
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("ignHsReady", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        check("ignNoCapture", 32'(in_ready), 32'd1);
        check("ignNoValid", 32'(out_valid), 32'd0);

        @(negedge clk);
        in_valid   = 1'b1;
        inputValue = 8'h16;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midRstReady", 32'(in_ready), 32'd1);
        check("midRstValid", 32'(out_valid), 32'd0);
        check("midRstData", 32'(sboxOutput), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        runByte(8'hc1, 0, res, lat);
        check("postRstData", 32'(res), 32'hdd);

`ifdef SBOX_FWD_MODE_EN
        fwd_mode = 1'b1;
        runByte(8'h00, 0, res, lat);
        check("fwd00", 32'(res), 32'h63);
        runByte(8'h77, 0, res, lat);
        check("fwd77", 32'(res), 32'hf5);
        runByte(8'hdd, 0, res, lat);
        check("fwddd", 32'(res), 32'hc1);
        for (int i = 0; i < 10; i++) begin
            v = 8'($urandom);
            runByte(v, 0, res, lat);
            check("fwdRnd", 32'(res), 32'(refFwd(v)));
        end
        fwd_mode = 1'b0;
        runByte(8'h63, 0, res, lat);
        check("fwdOff63", 32'(res), 32'h00);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
